// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the interrupt-capable CP0 block.
//   - CP0 register numbers for Status, Cause and EPC
//   - bit positions of the architectural fields inside those registers
//   - entry/return FSM state encoding
package cp0_pkg;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam int IE     = 0;  // Status.IE
  localparam int EXL    = 1;  // Status.EXL
  localparam int IM_LO  = 8;  // Status.IM[N_IRQ-1:0]
  localparam int IP_LO  = 8;  // Cause.IP[N_IRQ-1:0]
  localparam int EXC_LO = 2;  // Cause[4:2] winning line index

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: groups the mfc0/mtc0 register bus and the interrupt
// handshake between the pipeline and the CP0 interrupt controller.
//   master : pipeline side (drives addresses, write data, irq lines, ack/eret)
//   slave  : CP0 side (returns read data, request/vector, EPC and Status bits)
interface cp0_intc_if #(
  parameter int WIDTH = 32,
  parameter int N_IRQ = 6
);
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             we;
  logic [N_IRQ-1:0] irq_in;
  logic [WIDTH-1:0] pc_in;
  logic             int_ack;
  logic             eret;
  logic             int_req;
  logic [WIDTH-1:0] int_vector;
  logic [WIDTH-1:0] epc_out;
  logic             ie_out;
  logic             exl_out;

  modport master (
    output rd_addr, wr_addr, wr_data, we, irq_in, pc_in, int_ack, eret,
    input  rd_data, int_req, int_vector, epc_out, ie_out, exl_out
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, we, irq_in, pc_in, int_ack, eret,
    output rd_data, int_req, int_vector, epc_out, ie_out, exl_out
  );
endinterface

// File: rtl/cp0_irq_prio.sv
// cp0_irq_prio: pending latches, masking and fixed-priority selection.
//   clk, clr  : clock, asynchronous active-high reset
//   irq_in    : external interrupt lines
//   im        : Status.IM mask
//   ack_clr   : acknowledge of line ack_idx this cycle (edge mode clears it)
//   pending   : pending vector (mirrored into Cause.IP)
//   any_elig  : at least one pending & unmasked line
//   winner    : lowest-index eligible line (line 0 has highest priority)
module cp0_irq_prio #(
  parameter int N_IRQ     = 6,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] im,
  input  logic             ack_clr,
  input  logic [2:0]       ack_idx,
  output logic [N_IRQ-1:0] pending,
  output logic             any_elig,
  output logic [2:0]       winner
);
  logic [N_IRQ-1:0] irq_prev_reg;
  logic [N_IRQ-1:0] latch_reg;
  logic [N_IRQ-1:0] latch_next;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] elig;

  // Clear is applied before the set term so a fresh edge in the ack cycle
  // survives.
  always_comb begin
    clr_vec = '0;
    if (ack_clr) clr_vec = N_IRQ'(1) << ack_idx;
    latch_next = (latch_reg & ~clr_vec) | (irq_in & ~irq_prev_reg);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      irq_prev_reg <= '0;
      latch_reg    <= '0;
    end else begin
      irq_prev_reg <= irq_in;
      latch_reg    <= latch_next;
    end
  end

  // Level mode uses the live lines so a request can be raised the cycle
  // after irq_in rises.
  assign pending  = EDGE_MODE ? latch_reg : irq_in;
  assign elig     = pending & im;
  assign any_elig = |elig;

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    winner = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = 3'(i);
    end
  end
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 Status/Cause/EPC with N_IRQ maskable interrupt lines and an
// entry/return handshake with the pipeline.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset
//   bus : cp0_intc_if.slave -- mfc0/mtc0 ports (rd_*/wr_*/we), irq_in,
//         pc_in, int_ack, eret in; rd_data, int_req, int_vector, epc_out,
//         ie_out, exl_out out
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               N_IRQ      = 6,
  parameter bit               EDGE_MODE  = 1'b0,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_0400),
  parameter int               VEC_STRIDE = 8
) (
  input logic       clk,
  input logic       clr,
  cp0_intc_if.slave bus
);
  localparam logic [WIDTH-1:0] STRIDE = WIDTH'(VEC_STRIDE);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] status_reg, status_next;
  logic [WIDTH-1:0] cause_reg, cause_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic [WIDTH-1:0] vec_reg;
  logic [2:0]       win_reg;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] im;
  logic             any_elig;
  logic [2:0]       winner;
  logic             ie, exl, take_ack, win_ok, enter_req;

  assign im       = status_reg[IM_LO +: N_IRQ];
  assign ie       = status_reg[IE];
  assign exl      = status_reg[EXL];
  assign take_ack = (state_reg == REQ) && bus.int_ack;
  // Still eligible means the latched line is pending and unmasked now.
  assign win_ok   = |(pending & im & (N_IRQ'(1) << win_reg));

  cp0_irq_prio #(
    .N_IRQ     (N_IRQ),
    .EDGE_MODE (EDGE_MODE)
  ) u_prio (
    .clk      (clk),
    .clr      (clr),
    .irq_in   (bus.irq_in),
    .im       (im),
    .ack_clr  (take_ack),
    .ack_idx  (win_reg),
    .pending  (pending),
    .any_elig (any_elig),
    .winner   (winner)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_elig && ie && !exl) state_next = REQ;
      // Ack is checked first so it beats a simultaneous withdrawal.
      REQ: begin
        if (take_ack)                   state_next = SERVICE;
        else if (!win_ok || !ie || exl) state_next = IDLE;
      end
      SERVICE: if (bus.eret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_req = (state_reg == IDLE) && (state_next == REQ);

  // mtc0 lands first; the ack/eret fields are then overridden on top.
  always_comb begin
    status_next = status_reg;
    cause_next  = cause_reg;
    epc_next    = epc_reg;
    if (bus.we) begin
      case (bus.wr_addr)
        REG_STATUS: status_next = bus.wr_data;
        // IP bits are never stored; reads overlay the live pending vector.
        REG_CAUSE:  cause_next  = bus.wr_data & ~(WIDTH'({N_IRQ{1'b1}}) << IP_LO);
        REG_EPC:    epc_next    = bus.wr_data;
        default:    ;
      endcase
    end
    if (take_ack) begin
      status_next[EXL]          = 1'b1;
      cause_next[EXC_LO +: 3]   = win_reg;
      epc_next                  = bus.pc_in;
    end else if (bus.eret) begin
      status_next[EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= IDLE;
      status_reg <= '0;
      cause_reg  <= '0;
      epc_reg    <= '0;
      vec_reg    <= '0;
      win_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
      cause_reg  <= cause_next;
      epc_reg    <= epc_next;
      if (enter_req) begin
        win_reg <= winner;
        vec_reg <= VEC_BASE + WIDTH'(winner) * STRIDE;
      end
    end
  end

  always_comb begin
    case (bus.rd_addr)
      REG_STATUS: bus.rd_data = status_reg;
      REG_CAUSE:  bus.rd_data = cause_reg | (WIDTH'(pending) << IP_LO);
      REG_EPC:    bus.rd_data = epc_reg;
      default:    bus.rd_data = '0;
    endcase
  end

  assign bus.int_req    = (state_reg == REQ);
  assign bus.int_vector = vec_reg;
  assign bus.epc_out    = epc_reg;
  assign bus.ie_out     = ie;
  assign bus.exl_out    = exl;
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed bench for cp0_intc with one level-mode and one
// edge-mode instance sharing clock and reset.
module tb_cp0_intc;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cp0_intc_if #(.WIDTH(32), .N_IRQ(6)) lv_if ();
  cp0_intc_if #(.WIDTH(32), .N_IRQ(6)) ed_if ();

  cp0_intc #(.WIDTH(32), .N_IRQ(6), .EDGE_MODE(1'b0)) dut_lv (
    .clk (clk), .clr (clr), .bus (lv_if.slave)
  );
  cp0_intc #(.WIDTH(32), .N_IRQ(6), .EDGE_MODE(1'b1)) dut_ed (
    .clk (clk), .clr (clr), .bus (ed_if.slave)
  );

  typedef struct {
    logic [31:0] status;
    logic [5:0]  irq;
    logic        exp_req;
    logic [31:0] exp_vec;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    lv_if.rd_addr = 5'd0; lv_if.wr_addr = 5'd0; lv_if.wr_data = '0; lv_if.we = 1'b0;
    lv_if.irq_in = '0; lv_if.pc_in = '0; lv_if.int_ack = 1'b0; lv_if.eret = 1'b0;
    ed_if.rd_addr = 5'd0; ed_if.wr_addr = 5'd0; ed_if.wr_data = '0; ed_if.we = 1'b0;
    ed_if.irq_in = '0; ed_if.pc_in = '0; ed_if.int_ack = 1'b0; ed_if.eret = 1'b0;

    tbl[0] = '{32'h0000_3F01, 6'b100110, 1'b1, 32'h0000_0408};
    tbl[1] = '{32'h0000_3F01, 6'b100000, 1'b1, 32'h0000_0428};
    tbl[2] = '{32'h0000_3F01, 6'b000001, 1'b1, 32'h0000_0400};
    tbl[3] = '{32'h0000_3F00, 6'b000001, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'h0000_3F03, 6'b000001, 1'b0, 32'h0000_0000};
    tbl[5] = '{32'h0000_2001, 6'b100110, 1'b1, 32'h0000_0428};
    tbl[6] = '{32'h0000_0001, 6'b111111, 1'b0, 32'h0000_0000};
    tbl[7] = '{32'h0000_0C01, 6'b001100, 1'b1, 32'h0000_0410};

    // Reset state
    #2;
    lv_if.rd_addr = 5'd12; #1 chk("rst status", lv_if.rd_data, 32'h0);
    lv_if.rd_addr = 5'd13; #1 chk("rst cause", lv_if.rd_data, 32'h0);
    lv_if.rd_addr = 5'd14; #1 chk("rst epc", lv_if.rd_data, 32'h0);
    lv_if.rd_addr = 5'd7;  #1 chk("rst unmapped", lv_if.rd_data, 32'h0);
    chk("rst int_req", 32'(lv_if.int_req), 32'h0);
    chk("rst ed int_req", 32'(ed_if.int_req), 32'h0);
    clr = 1'b0;
    tick();

    // Table: status + lines -> request/vector, Cause.IP mirrors lines
    for (int i = 0; i < 8; i++) begin
      lv_if.we = 1'b1; lv_if.wr_addr = 5'd12; lv_if.wr_data = tbl[i].status;
      lv_if.irq_in = tbl[i].irq;
      tick();
      lv_if.we = 1'b0;
      tick();
      chk($sformatf("tbl%0d int_req", i), 32'(lv_if.int_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("tbl%0d vector", i), lv_if.int_vector, tbl[i].exp_vec);
      lv_if.rd_addr = 5'd13; #1;
      chk($sformatf("tbl%0d cause", i), lv_if.rd_data, 32'(tbl[i].irq) << 8);
      lv_if.irq_in = '0;
      lv_if.we = 1'b1; lv_if.wr_addr = 5'd12; lv_if.wr_data = 32'h0;
      tick();
      lv_if.we = 1'b0;
      tick(); tick();
      chk($sformatf("tbl%0d idle", i), 32'(lv_if.int_req), 32'h0);
    end

    // Level: request, ack, eret
    lv_if.we = 1'b1; lv_if.wr_addr = 5'd12; lv_if.wr_data = 32'h0000_0301;
    tick();
    lv_if.we = 1'b0;
    lv_if.irq_in = 6'b000010; #1;
    chk("lvl req same cycle", 32'(lv_if.int_req), 32'h0);
    tick();
    chk("lvl req n+1", 32'(lv_if.int_req), 32'h1);
    chk("lvl vector", lv_if.int_vector, 32'h0000_0408);
    lv_if.int_ack = 1'b1; lv_if.pc_in = 32'h0000_1234;
    tick();
    lv_if.int_ack = 1'b0;
    chk("lvl epc", lv_if.epc_out, 32'h0000_1234);
    chk("lvl exl", 32'(lv_if.exl_out), 32'h1);
    chk("lvl req after ack", 32'(lv_if.int_req), 32'h0);
    lv_if.rd_addr = 5'd13; #1;
    chk("lvl cause", lv_if.rd_data, 32'h0000_0204);
    lv_if.irq_in = '0; lv_if.eret = 1'b1;
    tick();
    lv_if.eret = 1'b0;
    chk("lvl exl after eret", 32'(lv_if.exl_out), 32'h0);
    lv_if.irq_in = 6'b000001;
    tick();
    chk("lvl idle re-req", 32'(lv_if.int_req), 32'h1);
    chk("lvl idle vector", lv_if.int_vector, 32'h0000_0400);
    lv_if.irq_in = '0;
    tick(); tick();
    chk("lvl line drop withdraw", 32'(lv_if.int_req), 32'h0);
    chk("lvl epc kept", lv_if.epc_out, 32'h0000_1234);

    // Priority: line 1 before line 5
    lv_if.we = 1'b1; lv_if.wr_addr = 5'd12; lv_if.wr_data = 32'h0000_3F01;
    lv_if.irq_in = 6'b100110;
    tick();
    lv_if.we = 1'b0;
    tick();
    chk("prio vector l1", lv_if.int_vector, 32'h0000_0408);
    lv_if.int_ack = 1'b1; lv_if.pc_in = 32'h0000_2000;
    tick();
    lv_if.int_ack = 1'b0;
    lv_if.irq_in = 6'b100000;
    chk("prio exl", 32'(lv_if.exl_out), 32'h1);
    lv_if.eret = 1'b1;
    tick();
    lv_if.eret = 1'b0;
    chk("prio gap", 32'(lv_if.int_req), 32'h0);
    tick();
    chk("prio req l5", 32'(lv_if.int_req), 32'h1);
    chk("prio vector l5", lv_if.int_vector, 32'h0000_0428);
    lv_if.int_ack = 1'b1; lv_if.pc_in = 32'h0000_3000;
    tick();
    lv_if.int_ack = 1'b0;
    lv_if.rd_addr = 5'd13; #1;
    chk("prio cause l5", lv_if.rd_data, 32'h0000_2014);
    lv_if.irq_in = '0; lv_if.eret = 1'b1;
    tick();
    lv_if.eret = 1'b0;
    chk("prio exl clear", 32'(lv_if.exl_out), 32'h0);

    // Withdrawal by mtc0 IE=0, then the same with ack
    lv_if.we = 1'b1; lv_if.wr_addr = 5'd12; lv_if.wr_data = 32'h0000_0301;
    lv_if.irq_in = 6'b000010;
    tick();
    lv_if.we = 1'b0;
    tick();
    chk("wd req", 32'(lv_if.int_req), 32'h1);
    lv_if.we = 1'b1; lv_if.wr_data = 32'h0000_0300;
    tick();
    lv_if.we = 1'b0;
    tick();
    chk("wd int_req", 32'(lv_if.int_req), 32'h0);
    chk("wd epc", lv_if.epc_out, 32'h0000_3000);
    chk("wd exl", 32'(lv_if.exl_out), 32'h0);
    lv_if.we = 1'b1; lv_if.wr_data = 32'h0000_0301;
    tick();
    lv_if.we = 1'b0;
    tick();
    chk("wd2 req", 32'(lv_if.int_req), 32'h1);
    lv_if.we = 1'b1; lv_if.wr_data = 32'h0000_0300;
    lv_if.int_ack = 1'b1; lv_if.pc_in = 32'h0000_5678;
    tick();
    lv_if.we = 1'b0; lv_if.int_ack = 1'b0;
    chk("wd2 epc", lv_if.epc_out, 32'h0000_5678);
    chk("wd2 exl", 32'(lv_if.exl_out), 32'h1);
    chk("wd2 ie", 32'(lv_if.ie_out), 32'h0);
    lv_if.rd_addr = 5'd12; #1;
    chk("wd2 status merge", lv_if.rd_data, 32'h0000_0302);
    lv_if.irq_in = '0;

    // Edge mode
    ed_if.we = 1'b1; ed_if.wr_addr = 5'd12; ed_if.wr_data = 32'h0000_0800;
    tick();
    ed_if.we = 1'b0;
    ed_if.irq_in = 6'b001000;
    tick();
    ed_if.irq_in = '0;
    tick(); tick();
    ed_if.rd_addr = 5'd13; #1;
    chk("edge ip held", ed_if.rd_data, 32'h0000_0800);
    chk("edge no req ie0", 32'(ed_if.int_req), 32'h0);
    ed_if.we = 1'b1; ed_if.wr_data = 32'h0000_0801;
    tick();
    ed_if.we = 1'b0;
    tick();
    chk("edge req", 32'(ed_if.int_req), 32'h1);
    chk("edge vector", ed_if.int_vector, 32'h0000_0418);
    ed_if.int_ack = 1'b1; ed_if.pc_in = 32'h0000_0040;
    tick();
    ed_if.int_ack = 1'b0;
    chk("edge cause after ack", ed_if.rd_data, 32'h0000_000C);
    chk("edge epc", ed_if.epc_out, 32'h0000_0040);
    ed_if.eret = 1'b1;
    tick();
    ed_if.eret = 1'b0;
    chk("edge exl clear", 32'(ed_if.exl_out), 32'h0);
    ed_if.irq_in = 6'b001000;
    tick();
    ed_if.irq_in = '0;
    chk("edge lat n+1", 32'(ed_if.int_req), 32'h0);
    tick();
    chk("edge lat n+2", 32'(ed_if.int_req), 32'h1);
    ed_if.int_ack = 1'b1; ed_if.irq_in = 6'b001000;
    tick();
    ed_if.int_ack = 1'b0; ed_if.irq_in = '0;
    chk("edge set wins", ed_if.rd_data, 32'h0000_080C);
    ed_if.eret = 1'b1;
    tick();
    ed_if.eret = 1'b0;
    tick();
    chk("edge re-req", 32'(ed_if.int_req), 32'h1);

    // Asynchronous reset between clock edges
    #3;
    clr = 1'b1;
    #1;
    chk("arst exl", 32'(lv_if.exl_out), 32'h0);
    chk("arst epc", lv_if.epc_out, 32'h0);
    chk("arst int_req", 32'(lv_if.int_req), 32'h0);
    chk("arst ed int_req", 32'(ed_if.int_req), 32'h0);
    chk("arst ed cause", ed_if.rd_data, 32'h0);
    #2;
    clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
